trace_buffer: RTL
=================

Name: trace_buffer

Overview:
- Parametrised retire-trace capture unit for the RISC-V core. Successor to the single-cycle instruction tracer.
- Records retired instructions and their register writeback into a circular buffer, tagged with sequence number and cycle stamp.
- Two modes:
  - Stream: lossy FIFO, drained continuously.
  - Window: post-mortem ring that keeps the last DEPTH retirements around a trigger, then freezes for dump.
- Sits beside the core's retire stage. The drain side feeds a bench monitor or a debug port.

Parameters:
XLEN, 32, width of pc and writeback data
DEPTH, 16, buffer entries; power of two, >=2
CNT_W, 32, width of sequence and cycle counters
POST_TRIG, 4, entries captured after trigger in window mode; 0..DEPTH-1

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  instruction retired this cycle
in_pc  input  XLEN  retired pc
in_inst  input  32  retired instruction word
in_rd_we  input  1  retired instruction writes rd
in_rd  input  5  destination register
in_rd_wdata  input  XLEN  writeback value
mode  input  1  0=stream, 1=window
trigger  input  1  window-mode trigger pulse
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_pc  output  XLEN  head pc
out_inst  output  32  head instruction
out_rd_we  output  1  head writeback enable
out_rd  output  5  head rd
out_rd_wdata  output  XLEN  head writeback value
out_seq  output  CNT_W  head sequence number
out_cycle  output  CNT_W  head cycle stamp
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: stream-mode entry dropped
frozen  output  1  window mode in DUMP

Behaviour:
- Reset (async, active-high):
  - All outputs 0. Buffer empty. Counters 0. State CAPTURE.
  - Buffer RAM contents are don't-care.
- cycle_ctr: increments every clock after reset; wraps at 2^CNT_W.
- seq_ctr: increments per accepted capture only; wraps at 2^CNT_W.
- A stored entry holds in_* fields plus seq_ctr and cycle_ctr as sampled that cycle.
- Output interface is first-word-fall-through:
  - out_* reflect the head entry combinationally from registered storage.
  - out_valid = (count!=0) && drain permitted.
  - Pop on out_valid && out_ready.
  - out_* fields are 0 whenever out_valid=0.
- Stream mode (mode=0):
  - Drain always permitted.
  - in_valid with count<DEPTH: push.
  - in_valid with count==DEPTH and pop same cycle: push and pop; count unchanged.
  - in_valid with count==DEPTH and no pop: entry dropped; seq_ctr still increments; overflow set, cleared only by reset.
  - frozen=0.
- Window mode (mode=1) state machine:
  - CAPTURE:
    - Every in_valid pushes. When full, the oldest entry is overwritten (head and tail both advance); count saturates at DEPTH; overflow untouched.
    - out_valid=0.
    - trigger -> POST with post_cnt=POST_TRIG, or -> DUMP directly if POST_TRIG=0.
    - Capture in the trigger cycle is still recorded.
  - POST:
    - Captures continue with overwrite semantics. post_cnt decrements per capture.
    - The capture that brings post_cnt to 0 moves to DUMP next cycle.
    - trigger is ignored.
  - DUMP:
    - frozen=1. in_valid ignored (seq_ctr frozen too). trigger ignored.
    - Drain permitted, oldest first.
    - On the pop that empties the buffer -> CAPTURE next cycle with frozen=0.
- Mode change:
  - Any cycle where mode differs from the previous cycle's registered value flushes the buffer (count=0) and forces CAPTURE.
  - A capture in that cycle is discarded.
  - overflow is retained.
- Counters and pointers are log2(DEPTH) bits and wrap naturally. count is a separate register, not a pointer difference.

Optional Feature:
- TRACE_DISPLAY_EN defined: on every pop, simulation prints one line:
  - seq, cycle, "0x%08x (0x%08x)" pc/inst
  - plus " x%0d <= 0x%08x" when out_rd_we && out_rd!=0.
  - In window mode, the first DUMP cycle also prints a "--- trigger dump ---" header.
- TRACE_DISPLAY_EN undefined: no $display statements are compiled. Logic and ports are identical.

Test Plan:
- Stream, DEPTH=16, out_ready=1:
  - Stimulus: retire pc 0x100..0x10C (4 insts).
  - Response: each appears one cycle after capture with seq 0..3; count never exceeds 1; overflow=0.
- Stream, out_ready=0:
  - Stimulus: 18 retirements.
  - Response: count=16; overflow=1 from the 17th; draining yields seq 0..15; next capture gets seq 18.
- Stream, full:
  - Stimulus: in_valid and out_ready asserted in the same cycle.
  - Response: count stays 16; overflow stays 0.
- Window, POST_TRIG=4:
  - Stimulus: 40 retirements, trigger at seq 30.
  - Response: DUMP after seq 34; frozen=1; drain yields seq 19..34; returns to CAPTURE with frozen=0 after the last pop.
- Window:
  - Stimulus: toggle mode to 0 during POST.
  - Response: count=0 next cycle; state CAPTURE; no out_valid.
- Reset mid-DUMP:
  - Stimulus: assert reset asynchronously between clock edges.
  - Response: all outputs 0 immediately; counters restart at 0 after release.

Source files
------------

// File: rtl/trace_buffer.sv
// trace_buffer
//   Retire-trace capture unit. Records retired instructions and their
//   register writeback into a circular buffer. Each entry is tagged with a
//   sequence number and a cycle stamp.
//
//   Modes:
//     stream (mode=0) : lossy FIFO that drains continuously. When the buffer
//                       is full, a new entry is dropped and the sticky
//                       overflow flag is set.
//     window (mode=1) : post-mortem ring. Entries are overwritten until a
//                       trigger arrives. POST_TRIG more retirements are then
//                       recorded, and the ring freezes (DUMP) until it has
//                       been drained.
//
//   Ports:
//     clk, reset               clock, asynchronous active-high reset
//     in_valid, in_pc, in_inst,
//     in_rd_we, in_rd,
//     in_rd_wdata              retire-stage capture inputs
//     mode, trigger            0=stream / 1=window, window trigger pulse
//     out_valid, out_ready,
//     out_*                    first-word-fall-through drain of the head entry
//     count                    current occupancy
//     overflow                 sticky: a stream-mode entry was dropped
//     frozen                   window mode is in DUMP
//
//   Optional feature: define TRACE_DISPLAY_EN to print every popped entry
//   during simulation. Logic and ports are the same with or without it.
module trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 32,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  input  logic                       in_rd_we,
  input  logic [4:0]                 in_rd,
  input  logic [XLEN-1:0]            in_rd_wdata,
  input  logic                       mode,
  input  logic                       trigger,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_rd_we,
  output logic [4:0]                 out_rd,
  output logic [XLEN-1:0]            out_rd_wdata,
  output logic [CNT_W-1:0]           out_seq,
  output logic [CNT_W-1:0]           out_cycle,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       frozen
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  typedef enum logic [1:0] {ST_CAPTURE, ST_POST, ST_DUMP} state_t;

  state_t            state, state_next;
  logic [AW-1:0]     head, tail;
  logic [AW-1:0]     post_cnt, post_next;
  logic [CNT_W-1:0]  seq_ctr, cycle_ctr;
  logic              mode_q;

  logic              mode_change, drain_ok, full, pop;
  logic              push, overwrite, seq_inc, set_ovf;

  logic [XLEN-1:0]   pc_mem    [DEPTH];
  logic [31:0]       inst_mem  [DEPTH];
  logic              we_mem    [DEPTH];
  logic [4:0]        rd_mem    [DEPTH];
  logic [XLEN-1:0]   wdata_mem [DEPTH];
  logic [CNT_W-1:0]  seq_mem   [DEPTH];
  logic [CNT_W-1:0]  cycle_mem [DEPTH];

  // A mode switch flushes the buffer. The drain is blocked in that same
  // cycle so that no entry is handed out and then discarded by the flush.
  assign mode_change = (mode != mode_q);
  assign full        = (count == FULL_CNT);
  assign drain_ok    = !mode || (state == ST_DUMP);
  assign out_valid   = (count != '0) && drain_ok && !mode_change;
  assign pop         = out_valid && out_ready;
  assign frozen      = (state == ST_DUMP);

  // The head entry falls through combinationally and is zeroed when not valid.
  assign out_pc       = out_valid ? pc_mem[head]    : '0;
  assign out_inst     = out_valid ? inst_mem[head]  : '0;
  assign out_rd_we    = out_valid ? we_mem[head]    : 1'b0;
  assign out_rd       = out_valid ? rd_mem[head]    : '0;
  assign out_rd_wdata = out_valid ? wdata_mem[head] : '0;
  assign out_seq      = out_valid ? seq_mem[head]   : '0;
  assign out_cycle    = out_valid ? cycle_mem[head] : '0;

  // Capture decisions and window-mode sequencing.
  // Window captures overwrite the oldest entry when the ring is full.
  // Stream captures drop the entry when the FIFO is full, unless a pop
  // makes room in the same cycle.
  always_comb begin
    state_next = state;
    post_next  = post_cnt;
    push       = 1'b0;
    overwrite  = 1'b0;
    seq_inc    = 1'b0;
    set_ovf    = 1'b0;
    if (mode_change) begin
      state_next = ST_CAPTURE;
    end else if (!mode) begin
      if (in_valid) begin
        seq_inc = 1'b1;
        if (!full || pop) push    = 1'b1;
        else              set_ovf = 1'b1;
      end
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (in_valid) begin
            push      = 1'b1;
            seq_inc   = 1'b1;
            overwrite = full;
          end
          if (trigger) begin
            post_next  = POST_INIT;
            state_next = (POST_TRIG == 0) ? ST_DUMP : ST_POST;
          end
        end
        ST_POST: begin
          if (in_valid) begin
            push      = 1'b1;
            seq_inc   = 1'b1;
            overwrite = full;
            post_next = post_cnt - AW'(1);
            if (post_cnt == AW'(1)) state_next = ST_DUMP;
          end
        end
        ST_DUMP: begin
          // Leave once the last entry is popped. Also leave if the ring is
          // already empty, which can happen when a trigger arrives on an
          // empty ring with POST_TRIG=0.
          if ((pop && count == CW'(1)) || count == '0) state_next = ST_CAPTURE;
        end
        default: state_next = ST_CAPTURE;
      endcase
    end
  end

  // State, pointers, occupancy and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_CAPTURE;
      post_cnt  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      seq_ctr   <= '0;
      cycle_ctr <= '0;
      mode_q    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      post_cnt  <= post_next;
      mode_q    <= mode;
      cycle_ctr <= cycle_ctr + CNT_W'(1);
      if (seq_inc) seq_ctr  <= seq_ctr + CNT_W'(1);
      if (set_ovf) overflow <= 1'b1;
      if (mode_change) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push)              tail <= tail + AW'(1);
        if (pop || overwrite)  head <= head + AW'(1);
        if (push && !overwrite && !pop)  count <= count + CW'(1);
        else if (pop && !push)           count <= count - CW'(1);
      end
    end
  end

  // Entry storage. It has no reset because the contents are don't-care
  // until they are written.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= in_pc;
      inst_mem[tail]  <= in_inst;
      we_mem[tail]    <= in_rd_we;
      rd_mem[tail]    <= in_rd;
      wdata_mem[tail] <= in_rd_wdata;
      seq_mem[tail]   <= seq_ctr;
      cycle_mem[tail] <= cycle_ctr;
    end
  end

`ifdef TRACE_DISPLAY_EN
  // Print a banner on the edge that enters DUMP, followed by one line per
  // popped entry.
  always @(posedge clk) begin
    if (!reset) begin
      if (mode && !mode_change && state != ST_DUMP && state_next == ST_DUMP)
        $display("--- trigger dump ---");
      if (pop) begin
        if (out_rd_we && out_rd != 5'd0)
          $display("%0d %0d 0x%08x (0x%08x) x%0d <= 0x%08x",
                   out_seq, out_cycle, out_pc, out_inst, out_rd, out_rd_wdata);
        else
          $display("%0d %0d 0x%08x (0x%08x)", out_seq, out_cycle, out_pc, out_inst);
      end
    end
  end
`endif

endmodule
